// File: rtl/usr_irq_pkg.sv
// Shared constants, mode encodings and FSM state type for the user-interrupt stimulus generator.
package usr_irq_pkg;

    localparam int USR_IRQ_N_DEF     = 6;
    localparam int USR_IRQ_SEL_W_DEF = 3;
    localparam int USR_IRQ_DLY_W_DEF = 8;
    localparam int USR_IRQ_CNT_W_DEF = 8;

    localparam logic [1:0] IRQ_LEVEL  = 2'd0;
    localparam logic [1:0] IRQ_PULSE  = 2'd1;
    localparam logic [1:0] IRQ_REPEAT = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_ASSERT = 2'd2,
        ST_GAP    = 2'd3
    } irq_state_e;

    // Encoding 3 has no meaning of its own and behaves as a single pulse.
    function automatic logic [1:0] norm_mode(input logic [1:0] mode);
        logic [1:0] res;
        case (mode)
            IRQ_LEVEL:  res = IRQ_LEVEL;
            IRQ_REPEAT: res = IRQ_REPEAT;
            default:    res = IRQ_PULSE;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/usr_irq_timer.sv
// Loadable down-counter shared by the delay, high-time and gap phases; stops at zero.
module usr_irq_timer
    import usr_irq_pkg::*;
#(
    parameter int DLY_W = USR_IRQ_DLY_W_DEF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [DLY_W-1:0] value_i,
    output logic             zero_o
);

    logic [DLY_W-1:0] cnt_q;
    logic [DLY_W-1:0] cnt_d;

    // Next count: load wins, otherwise decrement and hold at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = value_i;
        end else if (cnt_q != {DLY_W{1'b0}}) begin
            cnt_d = cnt_q - DLY_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= {DLY_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == {DLY_W{1'b0}});

endmodule

// File: rtl/usr_irq_stim.sv
// User-interrupt stimulus generator: turns a select change into a delayed level,
// pulse or repeating pulse on one IRQ line, with ack clearing and a fire counter.
module usr_irq_stim
    import usr_irq_pkg::*;
#(
    parameter int N_IRQ = USR_IRQ_N_DEF,
    parameter int SEL_W = USR_IRQ_SEL_W_DEF,
    parameter int DLY_W = USR_IRQ_DLY_W_DEF,
    parameter int CNT_W = USR_IRQ_CNT_W_DEF
) (
    input  logic             core_clk,
    input  logic             core_rstn,
    input  logic [SEL_W-1:0] irq_en_i,
    input  logic [1:0]       mode_i,
    input  logic [DLY_W-1:0] delay_i,
    input  logic [DLY_W-1:0] pulse_len_i,
    input  logic [N_IRQ-1:0] irq_ack_i,
    output logic [N_IRQ-1:0] irq_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] fire_cnt_o,
    output logic             sel_err_o
);

    logic [SEL_W-1:0] sel_q;
    logic             req_s;
    logic             sel_valid_s;
    logic             sel_inv_s;
    logic [N_IRQ-1:0] sel_oh_s;
    logic [DLY_W-1:0] len_m1_s;

    logic [N_IRQ-1:0] ch_oh_q;
    logic [1:0]       mode_q;
    logic [DLY_W-1:0] delay_q;
    logic [DLY_W-1:0] len_m1_q;

    irq_state_e       state_q, state_d;
    logic [N_IRQ-1:0] irq_q, irq_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] fire_cnt_q, fire_cnt_d;
    logic             sel_err_q, sel_err_d;

    logic             latch_s;
    logic             err_set_s;
    logic             tmr_load_s;
    logic [DLY_W-1:0] tmr_value_s;
    logic             tmr_zero_s;
    logic             ack_hit_s;
    logic             rise_s;

    assign req_s       = (irq_en_i != sel_q);
    assign sel_inv_s   = (irq_en_i > SEL_W'(N_IRQ));
    assign sel_valid_s = (irq_en_i != {SEL_W{1'b0}}) && !sel_inv_s;
    assign ack_hit_s   = |(irq_ack_i & ch_oh_q);
    assign rise_s      = |(irq_d & ~irq_q);

    // Select decoded to the target line as a one-hot mask (line k-1 for select k).
    always_comb begin
        sel_oh_s = {N_IRQ{1'b0}};
        for (int i = 0; i < N_IRQ; i++) begin
            sel_oh_s[i] = (irq_en_i == SEL_W'(i + 1));
        end
    end

    // A zero length counts as one cycle high, so the timer holds length minus one.
    always_comb begin
        len_m1_s = {DLY_W{1'b0}};
        if (pulse_len_i != {DLY_W{1'b0}}) begin
            len_m1_s = pulse_len_i - DLY_W'(1);
        end else begin
            len_m1_s = {DLY_W{1'b0}};
        end
    end

    usr_irq_timer #(
        .DLY_W (DLY_W)
    ) u_timer (
        .clk_i   (core_clk),
        .rst_ni  (core_rstn),
        .load_i  (tmr_load_s),
        .value_i (tmr_value_s),
        .zero_o  (tmr_zero_s)
    );

    // FSM next state, output line and timer control; a request event overrides everything.
    always_comb begin
        state_d     = state_q;
        irq_d       = irq_q;
        latch_s     = 1'b0;
        err_set_s   = 1'b0;
        tmr_load_s  = 1'b0;
        tmr_value_s = {DLY_W{1'b0}};
        if (req_s) begin
            irq_d = {N_IRQ{1'b0}};
            if (sel_valid_s) begin
                latch_s     = 1'b1;
                state_d     = ST_DELAY;
                tmr_load_s  = 1'b1;
                tmr_value_s = delay_i;
            end else begin
                state_d   = ST_IDLE;
                err_set_s = sel_inv_s;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_IDLE;
                end
                ST_DELAY, ST_GAP: begin
                    if (tmr_zero_s) begin
                        state_d     = ST_ASSERT;
                        irq_d       = ch_oh_q;
                        tmr_load_s  = 1'b1;
                        tmr_value_s = len_m1_q;
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_ASSERT: begin
                    if (mode_q == IRQ_LEVEL) begin
                        if (ack_hit_s) begin
                            irq_d   = {N_IRQ{1'b0}};
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_ASSERT;
                        end
                    end else if (tmr_zero_s) begin
                        irq_d = {N_IRQ{1'b0}};
                        if (mode_q == IRQ_REPEAT) begin
                            state_d     = ST_GAP;
                            tmr_load_s  = 1'b1;
                            tmr_value_s = delay_q;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_ASSERT;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    irq_d   = {N_IRQ{1'b0}};
                end
            endcase
        end
    end

    // Status next values: busy mirrors the next state, counter saturates, error is sticky.
    always_comb begin
        busy_d     = (state_d != ST_IDLE);
        sel_err_d  = sel_err_q | err_set_s;
        fire_cnt_d = fire_cnt_q;
        if (rise_s && (fire_cnt_q != {CNT_W{1'b1}})) begin
            fire_cnt_d = fire_cnt_q + CNT_W'(1);
        end else begin
            fire_cnt_d = fire_cnt_q;
        end
    end

    // Select tracking, FSM state and all registered outputs.
    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            sel_q      <= {SEL_W{1'b0}};
            state_q    <= ST_IDLE;
            irq_q      <= {N_IRQ{1'b0}};
            busy_q     <= 1'b0;
            fire_cnt_q <= {CNT_W{1'b0}};
            sel_err_q  <= 1'b0;
        end else begin
            sel_q      <= irq_en_i;
            state_q    <= state_d;
            irq_q      <= irq_d;
            busy_q     <= busy_d;
            fire_cnt_q <= fire_cnt_d;
            sel_err_q  <= sel_err_d;
        end
    end

    // Request parameters captured on a valid request; later input changes are ignored.
    always_ff @(posedge core_clk or negedge core_rstn) begin
        if (!core_rstn) begin
            ch_oh_q  <= {N_IRQ{1'b0}};
            mode_q   <= IRQ_LEVEL;
            delay_q  <= {DLY_W{1'b0}};
            len_m1_q <= {DLY_W{1'b0}};
        end else if (latch_s) begin
            ch_oh_q  <= sel_oh_s;
            mode_q   <= norm_mode(mode_i);
            delay_q  <= delay_i;
            len_m1_q <= len_m1_s;
        end else begin
            ch_oh_q  <= ch_oh_q;
            mode_q   <= mode_q;
            delay_q  <= delay_q;
            len_m1_q <= len_m1_q;
        end
    end

    assign irq_o      = irq_q;
    assign busy_o     = busy_q;
    assign fire_cnt_o = fire_cnt_q;
    assign sel_err_o  = sel_err_q;

endmodule

// File: tb/tb_usr_irq_stim.sv
// Bench for usr_irq_stim: cycle-offset model of the IRQ schedule checked every cycle,
// plus literal expectations along a directed scenario.
module tb_usr_irq_stim;

    logic       core_clk  = 1'b0;
    logic       core_rstn = 1'b1;
    logic [2:0] irq_en    = 3'd0;
    logic [1:0] mode      = 2'd0;
    logic [7:0] delay     = 8'd0;
    logic [7:0] plen      = 8'd0;
    logic [5:0] irq_ack   = 6'd0;
    logic [5:0] irq_out;
    logic       busy;
    logic [7:0] fire_cnt;
    logic       sel_err;

    int n_chk  = 0;
    int n_pass = 0;
    bit chk_en = 1'b0;

    // Model state: offset t from the request edge, latched parameters, expected outputs.
    logic [2:0] m_sel = 3'd0;
    bit         m_act = 1'b0;
    int         m_ch  = 0;
    int         m_md  = 0;
    int         m_d   = 0;
    int         m_l   = 1;
    int         m_t   = 0;
    logic [5:0] m_irq = 6'd0;
    int         m_cnt = 0;
    bit         m_err = 1'b0;

    always #5 core_clk = ~core_clk;

    usr_irq_stim dut (
        .core_clk    (core_clk),
        .core_rstn   (core_rstn),
        .irq_en_i    (irq_en),
        .mode_i      (mode),
        .delay_i     (delay),
        .pulse_len_i (plen),
        .irq_ack_i   (irq_ack),
        .irq_o       (irq_out),
        .busy_o      (busy),
        .fire_cnt_o  (fire_cnt),
        .sel_err_o   (sel_err)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge core_clk);
        #2;
    endtask

    // Behavioural model: output is a function of cycles elapsed since the request.
    initial begin
        bit         prev_hi;
        bit         new_hi;
        logic [5:0] one;
        forever begin
            @(posedge core_clk or negedge core_rstn);
            if (!core_rstn) begin
                m_sel = 3'd0; m_act = 1'b0; m_irq = 6'd0; m_cnt = 0; m_err = 1'b0;
            end else begin
                prev_hi = (m_irq != 6'd0);
                new_hi  = 1'b0;
                if (irq_en != m_sel) begin
                    m_sel = irq_en;
                    if (irq_en != 3'd0 && irq_en <= 3'd6) begin
                        m_act = 1'b1;
                        m_ch  = int'(irq_en) - 1;
                        m_md  = (mode == 2'd0) ? 0 : ((mode == 2'd2) ? 2 : 1);
                        m_d   = int'(delay);
                        m_l   = (plen == 8'd0) ? 1 : int'(plen);
                        m_t   = 0;
                    end else begin
                        m_act = 1'b0;
                        if (irq_en > 3'd6) m_err = 1'b1;
                    end
                end else if (m_act) begin
                    m_t++;
                    if (m_md == 0) begin
                        if (prev_hi && irq_ack[m_ch]) m_act = 1'b0;
                        else new_hi = (m_t >= m_d + 1);
                    end else if (m_md == 1) begin
                        new_hi = (m_t >= m_d + 1) && (m_t <= m_d + m_l);
                        if (m_t > m_d + m_l) m_act = 1'b0;
                    end else begin
                        new_hi = (m_t >= m_d + 1) && (((m_t - m_d - 1) % (m_l + m_d + 1)) < m_l);
                    end
                end
                if (new_hi && !prev_hi && m_cnt < 255) m_cnt++;
                one   = 6'd1;
                m_irq = new_hi ? (one << m_ch) : 6'd0;
            end
        end
    end

    // Compare process: every falling edge once checking is enabled.
    initial begin
        forever begin
            @(negedge core_clk);
            if (chk_en) begin
                chk("irq_o", {26'd0, irq_out}, {26'd0, m_irq});
                chk("busy_o", {31'd0, busy}, {31'd0, m_act});
                chk("fire_cnt_o", {24'd0, fire_cnt}, m_cnt);
                chk("sel_err_o", {31'd0, sel_err}, {31'd0, m_err});
            end
        end
    end

    initial begin
        #1 core_rstn = 1'b0;
        chk_en = 1'b1;
        tick(3);
        chk("rst_irq", {26'd0, irq_out}, 32'h0);
        chk("rst_cnt", {24'd0, fire_cnt}, 32'h0);
        core_rstn = 1'b1;
        tick(1);

        // PULSE on line 2, D=4, L=2
        mode = 2'd1; delay = 8'd4; plen = 8'd2; irq_en = 3'd3;
        tick(1);
        chk("p_busy_e0", {31'd0, busy}, 32'h1);
        tick(4);
        chk("p_low_e4", {26'd0, irq_out}, 32'h0);
        tick(1);
        chk("p_high_e5", {26'd0, irq_out}, 32'h04);
        tick(1);
        chk("p_high_e6", {26'd0, irq_out}, 32'h04);
        tick(1);
        chk("p_low_e7", {26'd0, irq_out}, 32'h0);
        chk("p_idle", {31'd0, busy}, 32'h0);
        chk("p_cnt", {24'd0, fire_cnt}, 32'h1);

        // LEVEL on line 5, D=0, wrong-line ack then right ack
        mode = 2'd0; delay = 8'd0; irq_en = 3'd6;
        tick(2);
        chk("l_high_e1", {26'd0, irq_out}, 32'h20);
        irq_ack = 6'b010000;
        tick(2);
        chk("l_wrong_ack", {26'd0, irq_out}, 32'h20);
        irq_ack = 6'b100000;
        tick(1);
        chk("l_ack_clear", {26'd0, irq_out}, 32'h0);
        irq_ack = 6'd0;
        tick(3);
        chk("l_no_refire", {26'd0, irq_out}, 32'h0);
        chk("l_cnt", {24'd0, fire_cnt}, 32'h2);

        // REPEAT on line 0, D=3, L=1: ten pulses at offsets 4,9,...,49
        mode = 2'd2; delay = 8'd3; plen = 8'd1; irq_en = 3'd1;
        tick(50);
        chk("r_cnt", {24'd0, fire_cnt}, 32'd12);
        chk("r_high_e49", {26'd0, irq_out}, 32'h01);
        irq_en = 3'd0;
        tick(1);
        chk("r_stop", {26'd0, irq_out}, 32'h0);
        chk("r_idle", {31'd0, busy}, 32'h0);

        // LEVEL abort 2 -> 5 with a same-cycle ack on the old line
        mode = 2'd0; delay = 8'd2; irq_en = 3'd2;
        tick(4);
        chk("a_old_high", {26'd0, irq_out}, 32'h02);
        irq_en = 3'd5; irq_ack = 6'b000010;
        tick(1);
        chk("a_drop_e0", {26'd0, irq_out}, 32'h0);
        irq_ack = 6'd0;
        tick(3);
        chk("a_new_high", {26'd0, irq_out}, 32'h10);
        chk("a_cnt", {24'd0, fire_cnt}, 32'd14);
        irq_ack = 6'b010000;
        tick(1);
        irq_ack = 6'd0;

        // Invalid select sets the sticky error
        irq_en = 3'd7;
        tick(4);
        chk("e_err", {31'd0, sel_err}, 32'h1);
        chk("e_irq", {26'd0, irq_out}, 32'h0);
        irq_en = 3'd0;
        tick(1);
        chk("e_sticky", {31'd0, sel_err}, 32'h1);

        // Mode 3 as PULSE, D=1, L=5; reset during assertion, select held
        mode = 2'd3; delay = 8'd1; plen = 8'd5; irq_en = 3'd2;
        tick(4);
        chk("x_high", {26'd0, irq_out}, 32'h02);
        core_rstn = 1'b0;
        #1;
        chk("x_async_irq", {26'd0, irq_out}, 32'h0);
        chk("x_async_err", {31'd0, sel_err}, 32'h0);
        chk("x_async_cnt", {24'd0, fire_cnt}, 32'h0);
        tick(2);
        core_rstn = 1'b1;
        tick(3);
        chk("x_refire", {26'd0, irq_out}, 32'h02);
        chk("x_cnt", {24'd0, fire_cnt}, 32'h1);
        tick(5);
        chk("x_idle", {31'd0, busy}, 32'h0);

        // REPEAT D=0, L=0 (one-cycle high): counter saturates
        mode = 2'd2; delay = 8'd0; plen = 8'd0; irq_en = 3'd3;
        tick(600);
        chk("s_sat", {24'd0, fire_cnt}, 32'd255);
        irq_en = 3'd0;
        tick(2);
        chk("s_stop", {26'd0, irq_out}, 32'h0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
